// File: rtl/timer_pkg.sv
// Shared definitions for the timer block: widths, register map, write-select bits
// and the prescaler terminal-count helper.
package timer_pkg;

    localparam int unsigned CNT_W   = 64;
    localparam int unsigned WORD_W  = CNT_W / 2;
    localparam int unsigned DIV_MAX = 8;
    localparam int unsigned DIV_W   = 4;
    localparam int unsigned PRESC_W = 8;

    // Register map of the upstream register block
    localparam logic [11:0] ADDR_TCR   = 12'h000;
    localparam logic [11:0] ADDR_TDR0  = 12'h004;
    localparam logic [11:0] ADDR_TDR1  = 12'h008;
    localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
    localparam logic [11:0] ADDR_TCMP1 = 12'h010;
    localparam logic [11:0] ADDR_TIER  = 12'h014;
    localparam logic [11:0] ADDR_TISR  = 12'h018;
    localparam logic [11:0] ADDR_THCSR = 12'h01C;

    // counter_write_sel bit positions
    localparam int unsigned SEL_LO = 0;
    localparam int unsigned SEL_HI = 1;

    typedef enum logic [1:0] {
        OpHold,
        OpClear,
        OpLoad,
        OpInc
    } cnt_op_e;

    // Terminal prescaler value (2^div - 1); out-of-range exponents saturate at DIV_MAX.
    function automatic logic [PRESC_W-1:0] presc_limit(input logic [DIV_W-1:0] div);
        logic [DIV_W-1:0]   d;
        logic [PRESC_W:0]   one_hot;
        logic [PRESC_W:0]   lim;
        d       = (div > DIV_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : div;
        one_hot = (PRESC_W + 1)'(1) << d;
        lim     = one_hot - (PRESC_W + 1)'(1);
        return lim[PRESC_W-1:0];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Programmable 2^N prescaler: counts while enabled and not halted, raises tc on the
// cycle whose edge should advance the main counter.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_en,
    input  logic               div_en,
    input  logic [DIV_W-1:0]   div_val,
    input  logic               halted,
    input  logic               counter_clear,
    output logic               tc
);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic [PRESC_W-1:0] limit;
    logic               at_limit;

    assign limit = presc_limit(div_val);
    // >= so that lowering div_val mid-count wraps at once instead of running to 2^PRESC_W
    assign at_limit = (presc_q >= limit);

    always_comb begin
        presc_d = presc_q;
        tc      = 1'b0;
        if (!timer_en || counter_clear) begin
            presc_d = '0;
        end else if (!halted) begin
            if (!div_en || at_limit) begin
                presc_d = '0;
                tc      = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// 64-bit timer count with clear/load/increment priority, prescaled increments and a
// registered debug-halt acknowledge.
module timer_counter
    import timer_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               timer_en,
    input  logic               div_en,
    input  logic [3:0]         div_val,
    input  logic               halt_req,
    input  logic               dbg_mode,
    input  logic               counter_clear,
    input  logic [1:0]         counter_write_sel,
    input  logic [31:0]        counter_write_data,
    output logic [63:0]        cnt_val,
    output logic               halt_ack_status,
    output logic               cnt_tick
);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              halt_q;
    logic              halt_d;
    logic              tick_q;
    logic              tick_d;
    logic              tc;
    cnt_op_e           cnt_op;
    logic [WORD_W-1:0] load_lo;
    logic [WORD_W-1:0] load_hi;

    timer_prescaler u_presc (
        .clk           (sys_clk),
        .rst           (sys_rst),
        .timer_en      (timer_en),
        .div_en        (div_en),
        .div_val       (div_val),
        .halted        (halt_q),
        .counter_clear (counter_clear),
        .tc            (tc)
    );

    always_comb begin
        cnt_op = OpHold;
        if (counter_clear) begin
            cnt_op = OpClear;
        end else if (|counter_write_sel) begin
            cnt_op = OpLoad;
        end else if (tc) begin
            cnt_op = OpInc;
        end
    end

    assign load_lo = counter_write_sel[SEL_LO] ? counter_write_data : cnt_q[WORD_W-1:0];
    assign load_hi = counter_write_sel[SEL_HI] ? counter_write_data : cnt_q[CNT_W-1:WORD_W];

    always_comb begin
        cnt_d = cnt_q;
        unique case (cnt_op)
            OpClear: cnt_d = '0;
            OpLoad:  cnt_d = {load_hi, load_lo};
            OpInc:   cnt_d = cnt_q + CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign tick_d = (cnt_op == OpInc);
    assign halt_d = halt_req & dbg_mode;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            halt_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            halt_q <= halt_d;
            tick_q <= tick_d;
        end
    end

    assign cnt_val         = cnt_q;
    assign halt_ack_status = halt_q;
    assign cnt_tick        = tick_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: stimulus pushes expected state, a negedge monitor checks.
module tb_timer_counter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        halt_req;
    logic        dbg_mode;
    logic        counter_clear;
    logic [1:0]  counter_write_sel;
    logic [31:0] counter_write_data;
    logic [63:0] cnt_val;
    logic        halt_ack_status;
    logic        cnt_tick;

    always #5 sys_clk = ~sys_clk;

    timer_counter dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .timer_en           (timer_en),
        .div_en             (div_en),
        .div_val            (div_val),
        .halt_req           (halt_req),
        .dbg_mode           (dbg_mode),
        .counter_clear      (counter_clear),
        .counter_write_sel  (counter_write_sel),
        .counter_write_data (counter_write_data),
        .cnt_val            (cnt_val),
        .halt_ack_status    (halt_ack_status),
        .cnt_tick           (cnt_tick)
    );

    typedef struct packed {
        logic [63:0] cnt;
        logic        ack;
        logic        tick;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic push_exp(input string nm, input logic [63:0] c, input logic a,
                            input logic t);
        exp_t e;
        e.cnt  = c;
        e.ack  = a;
        e.tick = t;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, so drain pending expectations at negedge
    always @(negedge sys_clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (cnt_val !== e.cnt || halt_ack_status !== e.ack || cnt_tick !== e.tick) begin
                bad++;
                $display("FAIL %s: got cnt=%h ack=%b tick=%b, want cnt=%h ack=%b tick=%b",
                         nm, cnt_val, halt_ack_status, cnt_tick, e.cnt, e.ack, e.tick);
            end
        end
    end

    initial begin
        int guard;
        sys_rst            = 1'b1;
        timer_en           = 1'b0;
        div_en             = 1'b0;
        div_val            = 4'd0;
        halt_req           = 1'b0;
        dbg_mode           = 1'b0;
        counter_clear      = 1'b0;
        counter_write_sel  = 2'b00;
        counter_write_data = 32'h0;

        step(2);
        push_exp("reset_state", 64'h0, 1'b0, 1'b0);
        sys_rst = 1'b0;

        // 1. Count to 0x10, then a short async reset pulse between edges
        timer_en = 1'b1;
        step(16);
        push_exp("count_to_16", 64'h10, 1'b0, 1'b1);
        @(negedge sys_clk);
        #1;
        timer_en = 1'b0;
        sys_rst  = 1'b1;
        #1;
        sys_rst  = 1'b0;
        push_exp("async_reset_mid_count", 64'h0, 1'b0, 1'b0);
        step(1);

        // 2. Prescale by 4 for 40 cycles, then undivided
        timer_en = 1'b1;
        div_en   = 1'b1;
        div_val  = 4'd2;
        step(40);
        push_exp("div4_40cyc", 64'd10, 1'b0, 1'b1);
        step(1);
        push_exp("div4_tick_pulse", 64'd10, 1'b0, 1'b0);
        step(3);
        push_exp("div4_next_inc", 64'd11, 1'b0, 1'b1);
        div_en             = 1'b0;
        counter_write_sel  = 2'b11;
        counter_write_data = 32'h0;
        step(1);
        push_exp("write_both_zero", 64'h0, 1'b0, 1'b0);
        counter_write_sel = 2'b00;
        step(40);
        push_exp("undiv_40cyc", 64'd40, 1'b0, 1'b1);

        // 3. Full 64-bit wrap and low-to-high carry
        timer_en           = 1'b0;
        counter_write_sel  = 2'b01;
        counter_write_data = 32'hFFFF_FFFE;
        step(1);
        counter_write_sel  = 2'b10;
        counter_write_data = 32'hFFFF_FFFF;
        step(1);
        push_exp("load_near_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        counter_write_sel = 2'b00;
        timer_en          = 1'b1;
        step(1);
        push_exp("wrap_all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        step(1);
        push_exp("wrap_zero", 64'h0, 1'b0, 1'b1);
        step(1);
        push_exp("wrap_one", 64'h1, 1'b0, 1'b1);
        timer_en           = 1'b0;
        counter_write_sel  = 2'b01;
        counter_write_data = 32'hFFFF_FFFF;
        step(1);
        counter_write_sel  = 2'b10;
        counter_write_data = 32'h0;
        step(1);
        push_exp("load_lo_ones", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        counter_write_sel = 2'b00;
        timer_en          = 1'b1;
        step(1);
        push_exp("carry_to_hi", 64'h1_0000_0000, 1'b0, 1'b1);

        // 4. Halt handshake with prescaler phase retention
        halt_req = 1'b1;
        dbg_mode = 1'b0;
        div_en   = 1'b1;
        div_val  = 4'd2;
        step(2);
        push_exp("halt_no_dbg", 64'h1_0000_0000, 1'b0, 1'b0);
        dbg_mode = 1'b1;
        step(1);
        push_exp("halt_ack_rise", 64'h1_0000_0000, 1'b1, 1'b0);
        step(3);
        push_exp("halt_frozen", 64'h1_0000_0000, 1'b1, 1'b0);
        dbg_mode = 1'b0;
        step(1);
        push_exp("halt_release", 64'h1_0000_0000, 1'b0, 1'b0);
        step(1);
        push_exp("resume_phase_kept", 64'h1_0000_0001, 1'b0, 1'b1);
        halt_req = 1'b0;

        // 5. Write and clear collisions
        step(3);
        push_exp("pre_collision", 64'h1_0000_0001, 1'b0, 1'b0);
        counter_write_sel  = 2'b01;
        counter_write_data = 32'h55;
        step(1);
        push_exp("write_beats_inc", 64'h1_0000_0055, 1'b0, 1'b0);
        counter_write_sel = 2'b00;
        step(4);
        push_exp("inc_after_write", 64'h1_0000_0056, 1'b0, 1'b1);
        counter_clear      = 1'b1;
        counter_write_sel  = 2'b10;
        counter_write_data = 32'hABCD;
        step(1);
        push_exp("clear_beats_write", 64'h0, 1'b0, 1'b0);
        counter_clear     = 1'b0;
        counter_write_sel = 2'b00;

        // 6. Disable with clear, then re-enable at divide-by-8
        step(4);
        push_exp("div4_after_clear", 64'h1, 1'b0, 1'b1);
        timer_en      = 1'b0;
        counter_clear = 1'b1;
        step(1);
        push_exp("disable_clear", 64'h0, 1'b0, 1'b0);
        counter_clear = 1'b0;
        step(2);
        push_exp("disabled_hold", 64'h0, 1'b0, 1'b0);
        timer_en = 1'b1;
        div_val  = 4'd3;
        step(7);
        push_exp("div8_before_tc", 64'h0, 1'b0, 1'b0);
        step(1);
        push_exp("div8_first_inc", 64'h1, 1'b0, 1'b1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge sys_clk);
            #1;
            guard++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
